// File: rtl/param_johnson_counter_if.sv
// Control and status bundle for param_johnson_counter.
// The master drives the controls and observes the counter; the counter is the slave.
interface param_johnson_counter_if #(
    parameter int WIDTH = 4
) ();
    localparam int IDX_W = $clog2(2 * WIDTH);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mode;
    logic             dir;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             wrap;
    logic             err;

    modport master (
        output en, load, load_val, mode, dir, err_clr,
        input  q, valid, idx, wrap, err
    );

    modport slave (
        input  en, load, load_val, mode, dir, err_clr,
        output q, valid, idx, wrap, err
    );
endinterface

// File: rtl/param_johnson_counter.sv
// Parameterised Johnson / one-hot ring counter with legality check, sequence
// decode, wrap pulse and sticky illegal-state flag.
module param_johnson_counter #(
    parameter int WIDTH        = 4,
    parameter bit AUTO_CORRECT = 1'b1,
    localparam int IDX_W       = $clog2(2 * WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    param_johnson_counter_if.slave bus
);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             wrap_reg, wrap_next;
    logic             err_reg, err_next;

    // Positions where adjacent bits differ; a Johnson code has at most one.
    logic [WIDTH-2:0] edge_bits;
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_edge
            assign edge_bits[gi] = q_reg[gi] ^ q_reg[gi+1];
        end
    endgenerate

    logic [IDX_W-1:0] ones_cnt;
    logic [IDX_W-1:0] edge_cnt;
    logic [IDX_W-1:0] ring_pos;
    logic [IDX_W-1:0] johnson_idx;
    logic [IDX_W-1:0] idx_c;
    logic             johnson_legal;
    logic             ring_legal;
    logic             valid_c;
    logic [WIDTH-1:0] init_state;
    logic [WIDTH-1:0] shifted;
    logic             fb_lsb;
    logic             fb_msb;

    always_comb begin
        ones_cnt = '0;
        ring_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_cnt = ones_cnt + IDX_W'(q_reg[i]);
            if (q_reg[i]) begin
                ring_pos = IDX_W'(i);
            end
        end
    end

    always_comb begin
        edge_cnt = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            edge_cnt = edge_cnt + IDX_W'(edge_bits[i]);
        end
    end

    assign johnson_legal = (edge_cnt <= IDX_W'(1));
    assign ring_legal    = (ones_cnt == IDX_W'(1));
    assign valid_c       = bus.mode ? ring_legal : johnson_legal;

    // Ones-filled-from-MSB codes count up by popcount; the draining half counts
    // down from 2*WIDTH so that a dir=0 step always advances idx by one.
    always_comb begin
        if (q_reg[WIDTH-1] || (q_reg == '0)) begin
            johnson_idx = ones_cnt;
        end else begin
            johnson_idx = IDX_W'(2 * WIDTH - int'(ones_cnt));
        end
    end

    always_comb begin
        idx_c = '0;
        if (valid_c) begin
            idx_c = bus.mode ? ring_pos : johnson_idx;
        end
    end

    assign init_state = bus.mode ? WIDTH'(1) : '0;

    // Johnson inverts the bit wrapping around; ring passes it through.
    assign fb_lsb  = bus.mode ? q_reg[0]       : ~q_reg[0];
    assign fb_msb  = bus.mode ? q_reg[WIDTH-1] : ~q_reg[WIDTH-1];
    assign shifted = bus.dir ? {q_reg[WIDTH-2:0], fb_msb}
                             : {fb_lsb, q_reg[WIDTH-1:1]};

    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        err_next  = err_reg;
        if (bus.load) begin
            q_next = bus.load_val;
        end else if (bus.en) begin
            if (!valid_c && AUTO_CORRECT) begin
                q_next = init_state;
            end else begin
                q_next = shifted;
            end
            wrap_next = valid_c && (shifted == init_state);
        end
        // A new illegal step outranks a simultaneous clear.
        if (bus.en && !bus.load && !valid_c) begin
            err_next = 1'b1;
        end else if (bus.err_clr) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
            err_reg  <= err_next;
        end
    end

    assign bus.q     = q_reg;
    assign bus.valid = valid_c;
    assign bus.idx   = idx_c;
    assign bus.wrap  = wrap_reg;
    assign bus.err   = err_reg;

endmodule

// File: tb/tb_param_johnson_counter.sv
// Directed bench for param_johnson_counter (WIDTH=4) with a scoreboard queue;
// instance A auto-corrects illegal states, instance B does not.
module tb_param_johnson_counter;

    logic clk;
    logic rst;

    param_johnson_counter_if #(.WIDTH(4)) ifa ();
    param_johnson_counter_if #(.WIDTH(4)) ifb ();

    param_johnson_counter #(.WIDTH(4), .AUTO_CORRECT(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    param_johnson_counter #(.WIDTH(4), .AUTO_CORRECT(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         sel;
        logic [3:0] q;
        logic       valid;
        logic [2:0] idx;
        logic       wrap;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input string tag, input bit sel, input logic [3:0] q,
                            input logic v, input logic [2:0] i,
                            input logic w, input logic e);
        exp_t x;
        x.tag = tag; x.sel = sel; x.q = q; x.valid = v; x.idx = i; x.wrap = w; x.err = e;
        sb.push_back(x);
    endtask

    task automatic compare_one();
        exp_t       x;
        logic [3:0] oq;
        logic       ov, ow, oe;
        logic [2:0] oi;
        x  = sb.pop_front();
        oq = x.sel ? ifb.q     : ifa.q;
        ov = x.sel ? ifb.valid : ifa.valid;
        oi = x.sel ? ifb.idx   : ifa.idx;
        ow = x.sel ? ifb.wrap  : ifa.wrap;
        oe = x.sel ? ifb.err   : ifa.err;
        $display("txn %s: q=%b valid=%b idx=%0d wrap=%b err=%b", x.tag, oq, ov, oi, ow, oe);
        checks++;
        assert (oq === x.q) else begin
            errors++; $error("FAIL %s.q observed=%b expected=%b", x.tag, oq, x.q);
        end
        checks++;
        assert (ov === x.valid) else begin
            errors++; $error("FAIL %s.valid observed=%b expected=%b", x.tag, ov, x.valid);
        end
        checks++;
        assert (oi === x.idx) else begin
            errors++; $error("FAIL %s.idx observed=%0d expected=%0d", x.tag, oi, x.idx);
        end
        checks++;
        assert (ow === x.wrap) else begin
            errors++; $error("FAIL %s.wrap observed=%b expected=%b", x.tag, ow, x.wrap);
        end
        checks++;
        assert (oe === x.err) else begin
            errors++; $error("FAIL %s.err observed=%b expected=%b", x.tag, oe, x.err);
        end
    endtask

    // One clock edge, then compare away from the edge.
    task automatic step(input string tag, input bit sel, input logic [3:0] q,
                        input logic v, input logic [2:0] i,
                        input logic w, input logic e);
        push_exp(tag, sel, q, v, i, w, e);
        @(posedge clk);
        #1;
        compare_one();
    endtask

    // Compare without a clock edge (combinational / asynchronous effects).
    task automatic now(input string tag, input bit sel, input logic [3:0] q,
                       input logic v, input logic [2:0] i,
                       input logic w, input logic e);
        push_exp(tag, sel, q, v, i, w, e);
        #1;
        compare_one();
    endtask

    initial begin
        rst = 1'b0;
        ifa.en = 0; ifa.load = 0; ifa.load_val = '0; ifa.mode = 0; ifa.dir = 0; ifa.err_clr = 0;
        ifb.en = 0; ifb.load = 0; ifb.load_val = '0; ifb.mode = 0; ifb.dir = 0; ifb.err_clr = 0;

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        now("rst_async_a", 0, 4'b0000, 1, 0, 0, 0);
        now("rst_async_b", 1, 4'b0000, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Johnson, dir=0: idx counts up, wrap after the 8th step
        ifa.en = 1;
        step("j_up1", 0, 4'b1000, 1, 1, 0, 0);
        step("j_up2", 0, 4'b1100, 1, 2, 0, 0);
        step("j_up3", 0, 4'b1110, 1, 3, 0, 0);
        step("j_up4", 0, 4'b1111, 1, 4, 0, 0);
        step("j_up5", 0, 4'b0111, 1, 5, 0, 0);
        step("j_up6", 0, 4'b0011, 1, 6, 0, 0);
        step("j_up7", 0, 4'b0001, 1, 7, 0, 0);
        step("j_up8", 0, 4'b0000, 1, 0, 1, 0);
        ifa.en = 0;
        step("j_hold", 0, 4'b0000, 1, 0, 0, 0);

        // Johnson, dir=1
        ifa.en = 1; ifa.dir = 1;
        step("j_dn1", 0, 4'b0001, 1, 7, 0, 0);
        step("j_dn2", 0, 4'b0011, 1, 6, 0, 0);
        step("j_dn3", 0, 4'b0111, 1, 5, 0, 0);
        step("j_dn4", 0, 4'b1111, 1, 4, 0, 0);
        step("j_dn5", 0, 4'b1110, 1, 3, 0, 0);

        // Mode change re-evaluates valid/idx immediately, q untouched
        ifa.en = 0; ifa.mode = 1;
        now("mode_ring_view", 0, 4'b1110, 0, 0, 0, 0);
        ifa.mode = 0;
        now("mode_john_view", 0, 4'b1110, 1, 3, 0, 0);

        // Load beats en; illegal pattern kept verbatim, then corrected
        ifa.load = 1; ifa.en = 1; ifa.load_val = 4'b0101;
        step("load_illegal", 0, 4'b0101, 0, 0, 0, 0);
        ifa.load = 0;
        step("auto_correct", 0, 4'b0000, 1, 0, 0, 1);
        ifa.en = 0; ifa.err_clr = 1;
        step("err_clear", 0, 4'b0000, 1, 0, 0, 0);
        ifa.err_clr = 0;

        // Ring mode
        ifa.mode = 1; ifa.load = 1; ifa.load_val = 4'b0001; ifa.dir = 0;
        step("r_load", 0, 4'b0001, 1, 0, 0, 0);
        ifa.load = 0; ifa.en = 1;
        step("r_dn1", 0, 4'b1000, 1, 3, 0, 0);
        step("r_dn2", 0, 4'b0100, 1, 2, 0, 0);
        step("r_dn3", 0, 4'b0010, 1, 1, 0, 0);
        step("r_dn4", 0, 4'b0001, 1, 0, 1, 0);
        ifa.en = 0; ifa.load = 1; ifa.load_val = 4'b1000;
        step("r_load8", 0, 4'b1000, 1, 3, 0, 0);
        ifa.load = 0; ifa.en = 1; ifa.dir = 1;
        step("r_up_wrap", 0, 4'b0001, 1, 0, 1, 0);

        // Set beats a simultaneous clear
        ifa.en = 0; ifa.load = 1; ifa.load_val = 4'b0011;
        step("r_load_bad", 0, 4'b0011, 0, 0, 0, 0);
        ifa.load = 0; ifa.en = 1; ifa.err_clr = 1;
        step("set_wins", 0, 4'b0001, 1, 0, 0, 1);
        ifa.en = 0;
        step("clear_only", 0, 4'b0001, 1, 0, 0, 0);
        ifa.err_clr = 0;

        // Reset mid-sequence overrides a pending load
        ifa.mode = 0; ifa.load = 1; ifa.load_val = 4'b1110;
        step("j_load_e", 0, 4'b1110, 1, 3, 0, 0);
        ifa.load_val = 4'b0101; ifa.en = 1;
        #3 rst = 1'b1;
        now("rst_mid", 0, 4'b0000, 1, 0, 0, 0);
        step("rst_held", 0, 4'b0000, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; ifa.load = 0; ifa.en = 0; ifa.mode = 1; ifa.dir = 0;
        now("ring_zero", 0, 4'b0000, 0, 0, 0, 0);
        ifa.en = 1;
        step("ring_zero_fix", 0, 4'b0001, 1, 0, 0, 1);
        ifa.en = 0;

        // No auto-correct: an illegal ring pattern is simply rotated
        ifb.mode = 1; ifb.load = 1; ifb.load_val = 4'b0011;
        step("b_load", 1, 4'b0011, 0, 0, 0, 0);
        ifb.load = 0; ifb.en = 1; ifb.dir = 0;
        step("b_rotate", 1, 4'b1001, 0, 0, 0, 1);
        ifb.en = 0;

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_johnson_counter.md
PARAM_JOHNSON_COUNTER -- requirements
Module: param_johnson_counter

Interface
REQ-001 Parameter: WIDTH, 4, register width in bits; legal range 2..32.
REQ-002 Parameter: AUTO_CORRECT, 1, when 1 a step from an illegal state forces the mode's initial state.
REQ-003 Derived localparam IDX_W = $clog2(2*WIDTH) SHALL size the idx port.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  step enable.
REQ-007 load  input  1  synchronous parallel load.
REQ-008 load_val  input  WIDTH  value captured on load.
REQ-009 mode  input  1  0 = Johnson (twisted ring), 1 = ring (one-hot rotate).
REQ-010 dir  input  1  0 = shift toward LSB, 1 = shift toward MSB.
REQ-011 err_clr  input  1  clears sticky err.
REQ-012 q  output  WIDTH  counter state (registered).
REQ-013 valid  output  1  combinational: q is a legal state for the current mode.
REQ-014 idx  output  IDX_W  combinational decoded sequence position of q.
REQ-015 wrap  output  1  registered one-cycle pulse on return to the initial state.
REQ-016 err  output  1  registered sticky illegal-state flag.

Function
REQ-017 Edge priority SHALL be: load, then en step, then hold; en is ignored while load=1.
REQ-018 Load SHALL write load_val to q unmodified, including illegal patterns.
REQ-019 Johnson step: dir=0 q <= {~q[0], q[WIDTH-1:1]}; dir=1 q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
REQ-020 Ring step: dir=0 q <= {q[0], q[WIDTH-1:1]}; dir=1 q <= {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-021 Initial state: Johnson = all zeros; ring = 1 (bit 0 set only).
REQ-022 Johnson legality: at most one index i in 0..WIDTH-2 has q[i] != q[i+1], giving exactly 2*WIDTH legal states.
REQ-023 Ring legality: exactly one bit of q set.
REQ-024 Johnson idx: popcount(q) if q[WIDTH-1]=1 or q=0, else 2*WIDTH - popcount(q).
REQ-025 Ring idx: bit position of the set bit.
REQ-026 idx SHALL be 0 whenever valid=0.
REQ-027 Consequence of REQ-024: dir=0 increments idx modulo 2*WIDTH and dir=1 decrements it.
REQ-028 Step with valid=0 and AUTO_CORRECT=1: q <= the mode's initial state instead of the shifted value.
REQ-029 Step with valid=0 and AUTO_CORRECT=0: normal shift.
REQ-030 err SHALL set on any edge with en=1, load=0 and valid=0.
REQ-031 err SHALL clear on err_clr=1; if set and clear occur on the same edge, set wins.
REQ-032 wrap SHALL be 1 for exactly the cycle after a normal (legal-state) step whose result is the initial state.
REQ-033 wrap SHALL NOT assert for load, correction, hold or reset.
REQ-034 A mode or dir change SHALL leave q unchanged; it takes effect on the next step, and valid/idx re-evaluate immediately.

Reset
REQ-035 rst=1 SHALL immediately, independent of clk, force q=0, wrap=0, err=0.
REQ-036 While rst=1 all inputs are ignored.
REQ-037 After rst deasserts, operation resumes on the next rising edge.
REQ-038 Ring mode with q=0 after reset is illegal; with AUTO_CORRECT=1 the first step loads 1 and sets err.

Verification (WIDTH=4)
REQ-039 Assert rst between edges -> q=0000, wrap=0, err=0 before the next edge; mode=0, dir=0, en=1 for 8 edges -> q 1000,1100,1110,1111,0111,0011,0001,0000, idx 1..7 then 0, wrap=1 only after the 8th edge.
REQ-040 mode=0, dir=1 from 0000 -> 0001 (idx 7), 0011 (6), 0111 (5), 1111 (4), 1110 (3).
REQ-041 load=1, en=1, load_val=0101, mode=0 -> q=0101, valid=0, idx=0; next en edge -> q=0000, err=1, wrap=0; err_clr alone -> err=0.
REQ-042 mode=1, load 0001, dir=0, en=1 for 4 edges -> 1000, 0100, 0010, 0001, idx 3,2,1,0, wrap after the 4th edge; dir=1 from 1000 -> 0001 with wrap.
REQ-043 err_clr=1 on an edge with an illegal step -> err stays 1; AUTO_CORRECT=0, mode=1, q=0011, step dir=0 -> q=1001, err=1.
REQ-044 Assert rst mid-sequence at q=1110 with load=1 -> q=0000 at once, load ignored, wrap never pulses.
